// File: rtl/scene_read_arbiter_pkg.sv
// Shared processor types for the scene read path plus the read-tag types the arbiter carries.
package scene_read_arbiter_pkg;

    localparam int LIGHT_ADDR_WIDTH    = 6;
    localparam int GEOMETRY_ADDR_WIDTH = 10;
    localparam int LIGHT_WIDTH         = 24;
    localparam int GEOMETRY_WIDTH      = 32;

    typedef logic [LIGHT_ADDR_WIDTH-1:0]    LightAddr;
    typedef logic [GEOMETRY_ADDR_WIDTH-1:0] GeometryAddr;
    typedef logic [LIGHT_WIDTH-1:0]         Light;

    // Tags are sized for the largest supported requester count.
    localparam int MAX_REQ   = 8;
    localparam int REQ_IDX_W = $clog2(MAX_REQ);

    typedef logic [REQ_IDX_W-1:0] ReqIdx;

    typedef struct packed {
        logic  valid;
        ReqIdx idx;
    } ReadTag;

    function automatic ReqIdx onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        ReqIdx idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) idx = ReqIdx'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scene_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid at or after ptr, ptr advances past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   ptr
);

    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               pos;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        cand     = '0;
        pos      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = IDX_W'(pos);
            if (enable && !found && valid[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
                ptr_next    = (pos == NUM_REQ - 1) ? '0 : IDX_W'(pos + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else     ptr <= ptr_next;
    end

endmodule

// File: rtl/scene_read_arbiter.sv
// Shares the light and geometry read ports among NUM_REQ requesters and routes fixed-latency responses back.
// Optional stall statistics are built only when SCENE_ARB_STATS_EN is defined.
module scene_read_arbiter
    import scene_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                      clk_100mhz,
    input  logic                      rst,
    input  logic                      mem_ready,
    input  logic [NUM_REQ-1:0]        lreq_valid,
    input  LightAddr                  lreq_addr [NUM_REQ],
    output logic [NUM_REQ-1:0]        lreq_ready,
    input  logic [NUM_REQ-1:0]        greq_valid,
    input  GeometryAddr               greq_addr [NUM_REQ],
    output logic [NUM_REQ-1:0]        greq_ready,
    output LightAddr                  light_read_addr,
    output GeometryAddr               geometry_read_addr,
    input  Light                      cur_light,
    input  logic [GEOMETRY_WIDTH-1:0] cur_geo,
    output logic [NUM_REQ-1:0]        lrsp_valid,
    output logic [NUM_REQ-1:0]        grsp_valid,
    output Light                      rsp_light,
    output logic [GEOMETRY_WIDTH-1:0] rsp_geo,
    output logic                      busy,
    output logic [31:0]               lstall_cnt,
    output logic [31:0]               gstall_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] lptr, gptr;
    ReqIdx            lidx, gidx;
    LightAddr         lheld;
    GeometryAddr      gheld;
    ReadTag           lpipe [READ_LATENCY];
    ReadTag           gpipe [READ_LATENCY];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_light_arb (
        .clk    (clk_100mhz),
        .rst    (rst),
        .valid  (lreq_valid),
        .enable (mem_ready),
        .grant  (lreq_ready),
        .ptr    (lptr)
    );

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_geo_arb (
        .clk    (clk_100mhz),
        .rst    (rst),
        .valid  (greq_valid),
        .enable (mem_ready),
        .grant  (greq_ready),
        .ptr    (gptr)
    );

    assign lidx = onehot_to_idx(MAX_REQ'(lreq_ready));
    assign gidx = onehot_to_idx(MAX_REQ'(greq_ready));

    // Granted address goes out combinationally; otherwise the last granted one is held.
    always_comb begin
        light_read_addr    = lheld;
        geometry_read_addr = gheld;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lreq_ready[i]) light_read_addr    = lreq_addr[i];
            if (greq_ready[i]) geometry_read_addr = greq_addr[i];
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            lheld <= '0;
            gheld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                lpipe[i] <= '0;
                gpipe[i] <= '0;
            end
        end else begin
            if (|lreq_ready) lheld <= light_read_addr;
            if (|greq_ready) gheld <= geometry_read_addr;
            lpipe[0] <= '{valid: |lreq_ready, idx: lidx};
            gpipe[0] <= '{valid: |greq_ready, idx: gidx};
            for (int i = 1; i < READ_LATENCY; i++) begin
                lpipe[i] <= lpipe[i-1];
                gpipe[i] <= gpipe[i-1];
            end
        end
    end

    always_comb begin
        lrsp_valid = '0;
        grsp_valid = '0;
        busy       = 1'b0;
        if (lpipe[READ_LATENCY-1].valid) lrsp_valid = NUM_REQ'(1) << lpipe[READ_LATENCY-1].idx;
        if (gpipe[READ_LATENCY-1].valid) grsp_valid = NUM_REQ'(1) << gpipe[READ_LATENCY-1].idx;
        for (int i = 0; i < READ_LATENCY; i++) begin
            busy = busy | lpipe[i].valid | gpipe[i].valid;
        end
    end

    assign rsp_light = cur_light;
    assign rsp_geo   = cur_geo;

    // The requester sitting at the pointer always has top priority when memory is readable.
    always @(posedge clk_100mhz) begin
        if (!rst && mem_ready && lreq_valid[lptr]) assert (lreq_ready[lptr]);
        if (!rst && mem_ready && greq_valid[gptr]) assert (greq_ready[gptr]);
    end

`ifdef SCENE_ARB_STATS_EN
    logic [31:0] lstall_q, gstall_q;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            lstall_q <= '0;
            gstall_q <= '0;
        end else begin
            if (|lreq_valid && !(|lreq_ready) && lstall_q != '1) lstall_q <= lstall_q + 32'd1;
            if (|greq_valid && !(|greq_ready) && gstall_q != '1) gstall_q <= gstall_q + 32'd1;
        end
    end

    assign lstall_cnt = lstall_q;
    assign gstall_cnt = gstall_q;
`else
    assign lstall_cnt = '0;
    assign gstall_cnt = '0;
`endif

endmodule

// File: tb/tb_scene_read_arbiter.sv
// Directed bench for scene_read_arbiter (NUM_REQ=4, READ_LATENCY=2) with a two-cycle stubbed scene memory.
module tb_scene_read_arbiter;
    import scene_read_arbiter_pkg::*;

    logic                      clk_100mhz = 1'b0;
    logic                      rst = 1'b1;
    logic                      mem_ready = 1'b0;
    logic [3:0]                lreq_valid = '0;
    LightAddr                  lreq_addr [4];
    logic [3:0]                lreq_ready;
    logic [3:0]                greq_valid = '0;
    GeometryAddr               greq_addr [4];
    logic [3:0]                greq_ready;
    LightAddr                  light_read_addr;
    GeometryAddr               geometry_read_addr;
    Light                      cur_light;
    logic [GEOMETRY_WIDTH-1:0] cur_geo;
    logic [3:0]                lrsp_valid, grsp_valid;
    Light                      rsp_light;
    logic [GEOMETRY_WIDTH-1:0] rsp_geo;
    logic                      busy;
    logic [31:0]               lstall_cnt, gstall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    scene_read_arbiter #(.NUM_REQ(4), .READ_LATENCY(2)) dut (
        .clk_100mhz         (clk_100mhz),
        .rst                (rst),
        .mem_ready          (mem_ready),
        .lreq_valid         (lreq_valid),
        .lreq_addr          (lreq_addr),
        .lreq_ready         (lreq_ready),
        .greq_valid         (greq_valid),
        .greq_addr          (greq_addr),
        .greq_ready         (greq_ready),
        .light_read_addr    (light_read_addr),
        .geometry_read_addr (geometry_read_addr),
        .cur_light          (cur_light),
        .cur_geo            (cur_geo),
        .lrsp_valid         (lrsp_valid),
        .grsp_valid         (grsp_valid),
        .rsp_light          (rsp_light),
        .rsp_geo            (rsp_geo),
        .busy               (busy),
        .lstall_cnt         (lstall_cnt),
        .gstall_cnt         (gstall_cnt)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    function automatic Light lmem(input LightAddr a);
        return {a, ~a, a, ~a};
    endfunction

    function automatic logic [GEOMETRY_WIDTH-1:0] gmem(input GeometryAddr a);
        return {a, ~a, 12'hABC};
    endfunction

    // Scene memory stub: data for an address appears two cycles after it is presented.
    LightAddr    la_d1, la_d2;
    GeometryAddr ga_d1, ga_d2;
    always @(posedge clk_100mhz) begin
        la_d1 <= light_read_addr;
        la_d2 <= la_d1;
        ga_d1 <= geometry_read_addr;
        ga_d2 <= ga_d1;
    end
    assign cur_light = lmem(la_d2);
    assign cur_geo   = gmem(ga_d2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_100mhz);
        #1;
    endtask

`ifdef SCENE_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        for (int i = 0; i < 4; i++) begin
            lreq_addr[i] = '0;
            greq_addr[i] = '0;
        end

        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_lrsp", lrsp_valid, 0);
        check("rst_grsp", grsp_valid, 0);
        check("rst_laddr", light_read_addr, 0);
        check("rst_gaddr", geometry_read_addr, 0);
        check("rst_lstall", lstall_cnt, 0);
        check("rst_gstall", gstall_cnt, 0);
        cyc();
        cyc();
        rst = 1'b0;

        // All four requesters ask for light at once
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) lreq_addr[i] = LightAddr'(10 + i);
        lreq_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_ready = (c < 4) ? 4'(1 << c) : 4'b0000;
            exp_rsp   = (c >= 2) ? 4'(1 << (c - 2)) : 4'b0000;
            check("t1_lready", lreq_ready, exp_ready);
            check("t1_lrsp", lrsp_valid, exp_rsp);
            check("t1_busy", busy, (c >= 1) ? 1 : 0);
            if (c < 4) check("t1_laddr", light_read_addr, LightAddr'(10 + c));
            if (c >= 2) check("t1_rsp_light", rsp_light, lmem(LightAddr'(10 + c - 2)));
            cyc();
            lreq_valid = lreq_valid & ~exp_ready;
        end
        #1;
        check("t1_busy_end", busy, 0);
        check("t1_laddr_held", light_read_addr, 13);

        // Single requester 2 at address 5
        lreq_addr[2] = 6'd5;
        lreq_valid = 4'b0100;
        #1;
        check("t2_lready", lreq_ready, 4'b0100);
        check("t2_laddr", light_read_addr, 5);
        cyc();
        lreq_valid = 4'b0000;
        #1;
        check("t2_laddr_held", light_read_addr, 5);
        check("t2_lrsp_early", lrsp_valid, 0);
        cyc();
        #1;
        check("t2_lrsp", lrsp_valid, 4'b0100);
        check("t2_rsp_light", rsp_light, lmem(6'd5));
        check("t2_laddr_held2", light_read_addr, 5);
        cyc();

        // Geometry requests while memory is not ready
        mem_ready = 1'b0;
        greq_addr[0] = 10'd20;
        greq_addr[2] = 10'd22;
        greq_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_gready_stalled", greq_ready, 0);
            cyc();
            check("t3_gstall", gstall_cnt, STATS ? 32'(k + 1) : 32'd0);
        end
        mem_ready = 1'b1;
        #1;
        check("t3_gready0", greq_ready, 4'b0001);
        check("t3_gaddr0", geometry_read_addr, 20);
        cyc();
        greq_valid = 4'b0100;
        #1;
        check("t3_gready2", greq_ready, 4'b0100);
        check("t3_gaddr2", geometry_read_addr, 22);
        cyc();
        greq_valid = 4'b0000;
        #1;
        check("t3_grsp0", grsp_valid, 4'b0001);
        check("t3_rsp_geo0", rsp_geo, gmem(10'd20));
        cyc();
        #1;
        check("t3_grsp2", grsp_valid, 4'b0100);
        check("t3_rsp_geo2", rsp_geo, gmem(10'd22));
        check("t3_gstall_hold", gstall_cnt, STATS ? 32'd3 : 32'd0);
        check("t3_lstall", lstall_cnt, 0);
        cyc();
        cyc();

        // Requester 1 reads light and geometry in the same cycle
        lreq_addr[1] = 6'd3;
        greq_addr[1] = 10'd7;
        lreq_valid = 4'b0010;
        greq_valid = 4'b0010;
        #1;
        check("t4_lready", lreq_ready, 4'b0010);
        check("t4_gready", greq_ready, 4'b0010);
        check("t4_laddr", light_read_addr, 3);
        check("t4_gaddr", geometry_read_addr, 7);
        cyc();
        lreq_valid = 4'b0000;
        greq_valid = 4'b0000;
        #1;
        check("t4_lrsp_early", lrsp_valid, 0);
        check("t4_grsp_early", grsp_valid, 0);
        cyc();
        #1;
        check("t4_lrsp", lrsp_valid, 4'b0010);
        check("t4_grsp", grsp_valid, 4'b0010);
        check("t4_rsp_light", rsp_light, lmem(6'd3));
        check("t4_rsp_geo", rsp_geo, gmem(10'd7));
        cyc();

        // mem_ready drops right after a grant; the read still completes
        lreq_addr[0] = 6'd9;
        lreq_valid = 4'b0001;
        #1;
        check("t5_busy_n", busy, 0);
        check("t5_lready", lreq_ready, 4'b0001);
        cyc();
        lreq_valid = 4'b0000;
        mem_ready = 1'b0;
        #1;
        check("t5_busy_n1", busy, 1);
        check("t5_lrsp_n1", lrsp_valid, 0);
        cyc();
        #1;
        check("t5_busy_n2", busy, 1);
        check("t5_lrsp_n2", lrsp_valid, 4'b0001);
        check("t5_rsp_light", rsp_light, lmem(6'd9));
        cyc();
        #1;
        check("t5_busy_n3", busy, 0);
        check("t5_lrsp_n3", lrsp_valid, 0);
        mem_ready = 1'b1;

        // Reset while two reads are in flight
        lreq_addr[3] = 6'd1;
        greq_addr[2] = 10'd2;
        lreq_valid = 4'b1000;
        greq_valid = 4'b0100;
        #1;
        check("t6_lready", lreq_ready, 4'b1000);
        check("t6_gready", greq_ready, 4'b0100);
        cyc();
        lreq_valid = 4'b0000;
        greq_valid = 4'b0000;
        #1;
        check("t6_busy_inflight", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_lrsp", lrsp_valid, 0);
        check("t6_rst_grsp", grsp_valid, 0);
        check("t6_rst_laddr", light_read_addr, 0);
        check("t6_rst_gaddr", geometry_read_addr, 0);
        check("t6_rst_gstall", gstall_cnt, 0);
        cyc();
        cyc();
        rst = 1'b0;
        lreq_valid = 4'b1111;
        greq_valid = 4'b1111;
        #1;
        check("t6_lready_after", lreq_ready, 4'b0001);
        check("t6_gready_after", greq_ready, 4'b0001);
        cyc();
        lreq_valid = 4'b0000;
        greq_valid = 4'b0000;

        // Light stall counting
        mem_ready = 1'b0;
        lreq_valid = 4'b0011;
        cyc();
        cyc();
        #1;
        check("t7_lstall", lstall_cnt, STATS ? 32'd2 : 32'd0);
        check("t7_lready", lreq_ready, 0);
        lreq_valid = 4'b0000;
        mem_ready = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/scene_read_arbiter.md
Name: scene_read_arbiter

Overview:
- Shares the execute stage's single light read port and single geometry read port among NUM_REQ render requesters (ray/shade units).
- Drives light_read_addr and geometry_read_addr into the instruction processor and issues grants only while mem_ready is high.
- Tracks each in-flight read through a fixed-latency tag pipeline and returns cur_light / cur_geo to the requester that issued it.
- The light and geometry channels are independent, so each can complete one read per cycle.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- READ_LATENCY, 2: cycles from address presented to cur_light/cur_geo valid, 1..4.

Ports:
- clk_100mhz  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mem_ready  in  1  scene memory readable; no grants while low.
- lreq_valid  in  NUM_REQ  per-requester light read request.
- lreq_addr  in  NUM_REQ x LightAddr  light address per requester.
- lreq_ready  out  NUM_REQ  one-hot light grant, combinational.
- greq_valid  in  NUM_REQ  per-requester geometry read request.
- greq_addr  in  NUM_REQ x GeometryAddr  geometry address per requester.
- greq_ready  out  NUM_REQ  one-hot geometry grant, combinational.
- light_read_addr  out  LightAddr  to processor.
- geometry_read_addr  out  GeometryAddr  to processor.
- cur_light  in  Light  light read data from processor.
- cur_geo  in  GEOMETRY_WIDTH  geometry read data from processor.
- lrsp_valid  out  NUM_REQ  one-hot light response strobe.
- grsp_valid  out  NUM_REQ  one-hot geometry response strobe.
- rsp_light  out  Light  broadcast of cur_light.
- rsp_geo  out  GEOMETRY_WIDTH  broadcast of cur_geo.
- busy  out  1  any read in flight on either channel.
- lstall_cnt, gstall_cnt  out  32 each  statistics counters (see Optional Feature).

Behaviour:
- Handshake: a requester holds valid and addr stable until it sees ready high in the same cycle. A transfer occurs when valid and ready are both high. A requester may raise valid again in the next cycle.
- Arbitration, per channel:
  - Round-robin pointer ptr, reset value 0.
  - Grant goes to the first i with valid[i] set, searching from ptr upward with wrap.
  - At most one grant per cycle, and only when mem_ready is 1.
  - On grant to i, ptr becomes (i+1) mod NUM_REQ at the next edge. ptr is unchanged when there is no grant.
- Address:
  - In a grant cycle, *_read_addr is combinationally muxed from the granted requester.
  - Otherwise it holds the last granted address from a register, reset value 0.
- Tag pipeline, per channel: READ_LATENCY stages of {valid, index}.
  - A grant in cycle N inserts {1, i}.
  - In cycle N+READ_LATENCY the last stage drives lrsp_valid[i] / grsp_valid[i] high for exactly one cycle.
  - rsp_light / rsp_geo pass cur_light / cur_geo through in that cycle. Requesters sample the data only while their strobe is high.
- mem_ready falling: new grants stop immediately. Entries already in flight still complete and are delivered.
- Simultaneous light and geometry requests from the same requester are granted independently. Both responses may return in the same cycle.
- busy = OR of all stage valid bits on both channels.
- Reset, asynchronous and legal mid-operation:
  - ptr = 0, pipelines cleared, held addresses = 0.
  - All rsp_valid = 0, busy = 0.
  - Reads in flight at reset are lost; requesters are reset by the same rst.
- Index width is $clog2(NUM_REQ). Addresses are passed through unmodified.

Optional Feature:
- Macro: SCENE_ARB_STATS_EN.
- Defined:
  - lstall_cnt / gstall_cnt count cycles in which at least one valid is high on that channel but no grant is issued (mem_ready low).
  - 32-bit counters that saturate at all-ones and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter registers are built.

Decomposition:
- Add to proctypes: ReqIdx typedef and a ReadTag struct {valid, ReqIdx idx}.
- Reuse the existing LightAddr, GeometryAddr, Light and GEOMETRY_WIDTH from proctypes.
- Sub-module rr_arbiter, parameterised on NUM_REQ, with inputs valid vector and enable, and outputs one-hot grant and the pointer register. It is instantiated once per channel.

Test Plan:
- NUM_REQ=4, READ_LATENCY=2, mem_ready=1, lreq_valid=4'b1111 held for 4 cycles:
  - Grants go to 0, 1, 2, 3 in order.
  - lrsp_valid = 0001, 0010, 0100, 1000 on cycles 3..6.
  - rsp_light equals the stubbed memory contents at each requester's address.
- Only requester 2 requests light at address 5:
  - lreq_ready[2] is high in the same cycle.
  - light_read_addr = 5 in that cycle and is held at 5 afterwards.
  - lrsp_valid[2] pulses 2 cycles later.
- mem_ready=0 with greq_valid=4'b0101:
  - No grant; with the macro, gstall_cnt increments every cycle.
  - After mem_ready=1, requester 0 is granted first, then requester 2.
- Requester 1 issues light addr 3 and geometry addr 7 in the same cycle: both are granted, and lrsp_valid[1] and grsp_valid[1] pulse together at N+2.
- Grant at cycle N, mem_ready drops at N+1: response still delivered at N+2; busy goes high at N+1 and low at N+3.
- rst asserted while 2 reads are in flight:
  - busy, lrsp_valid and grsp_valid are 0 immediately, with no clock edge needed.
  - After release, requester 0 has priority.
